// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC and keeps at most one imem request in flight.
// Hands one registered instruction at a time to decode over a valid/ready handshake.
module ysyx_23060096_ifu #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = 32'h8000_0000,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      id_op,
  output logic [2:0]      id_func3,
  output logic [6:0]      id_func7,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);

  localparam int unsigned ILEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic [ILEN-1:0]   id_instr_q, id_instr_d;
  logic              req_valid_q, req_valid_d;
  logic              id_valid_q, id_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [XLEN-1:0]   next_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      kill_q      <= 1'b0;
      id_pc_q     <= '0;
      id_instr_q  <= NOP_INSTR;
      req_valid_q <= 1'b0;
      id_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      kill_q      <= kill_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      req_valid_q <= req_valid_d;
      id_valid_q  <= id_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state logic; any transition into REQ with a misaligned address lands in ERR instead.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    next_addr  = redirect_valid ? redirect_pc : pc_q;

    if (redirect_valid) pc_d = redirect_pc;

    case (state_q)
      ST_IDLE: begin
        req_addr_d = next_addr;
        state_d    = (next_addr[1:0] != 2'b00) ? ST_ERR : ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) kill_d = 1'b1;
        if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_valid || kill_q) begin
            kill_d     = 1'b0;
            req_addr_d = next_addr;
            state_d    = (next_addr[1:0] != 2'b00) ? ST_ERR : ST_REQ;
          end else if (imem_rsp_err) begin
            state_d = ST_ERR;
          end else begin
            id_instr_d = imem_rsp_data;
            id_pc_d    = req_addr_q;
            state_d    = ST_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          id_instr_d = NOP_INSTR;
          state_d    = ST_IDLE;
        end else if (id_ready) begin
          pc_d       = pc_q + XLEN'(4);
          id_instr_d = NOP_INSTR;
          state_d    = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (redirect_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_valid_d = (state_d == ST_REQ);
    id_valid_d  = (state_d == ST_HOLD);
    fetch_err_d = (state_d == ST_ERR);
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_instr       = id_instr_q;
  assign id_op          = id_instr_q[6:0];
  assign id_func3       = id_instr_q[14:12];
  assign id_func7       = id_instr_q[31:25];
  assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Directed bench for ysyx_23060096_ifu: hand-driven imem and decode sides,
// outputs sampled 1ns after each rising edge.
module tb_ysyx_23060096_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_op;
  logic [2:0]  id_func3;
  logic [6:0]  id_func7;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  int checks;
  int failures;

  ysyx_23060096_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_op          (id_op),
    .id_func3       (id_func3),
    .id_func7       (id_func7),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From REQ with ready high: accept, then answer in the next cycle.
  task automatic do_fetch(input logic [31:0] data, input logic err);
    tick();
    chk("req_drop_after_accept", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
  endtask

  // From HOLD: consume, land in IDLE, then REQ.
  task automatic consume();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("consume_valid_drop", 32'(id_valid), 32'd0);
    chk("consume_nop", id_instr, 32'h0000_0013);
    tick();
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    tick();
    tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);

    // Sequential fetch with 1-cycle memory and ready decode
    rst_n = 1'b1;
    tick();
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_addr0", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1'b1;
    do_fetch(32'h40b5_0533, 1'b0);
    chk("t1_id_valid0", 32'(id_valid), 32'd1);
    chk("t1_id_pc0", id_pc, 32'h8000_0000);
    chk("t1_instr0", id_instr, 32'h40b5_0533);
    chk("t1_op0", 32'(id_op), 32'h33);
    chk("t1_func3_0", 32'(id_func3), 32'd0);
    chk("t1_func7_0", 32'(id_func7), 32'h20);
    consume();
    chk("t1_addr1", imem_req_addr, 32'h8000_0004);
    do_fetch(32'h0020_a023, 1'b0);
    chk("t1_id_pc1", id_pc, 32'h8000_0004);
    chk("t1_op1", 32'(id_op), 32'h23);
    chk("t1_func3_1", 32'(id_func3), 32'd2);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 32'(id_valid), 32'd1);
      chk("t2_hold_instr", id_instr, 32'h0020_a023);
      chk("t2_hold_func7", 32'(id_func7), 32'd0);
      chk("t2_no_req", 32'(imem_req_valid), 32'd0);
    end
    consume();
    chk("t1_addr2", imem_req_addr, 32'h8000_0008);

    // Redirect in WAIT coinciding with the response
    tick();
    redirect(32'h8000_0100);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("t3_id_valid", 32'(id_valid), 32'd0);
    chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_addr", imem_req_addr, 32'h8000_0100);
    do_fetch(32'h0010_0113, 1'b0);
    chk("t3_id_pc", id_pc, 32'h8000_0100);
    chk("t3_instr", id_instr, 32'h0010_0113);

    // Redirect in HOLD together with id_ready
    id_ready = 1'b1;
    redirect(32'h8000_0200);
    tick();
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("t4_valid_drop", 32'(id_valid), 32'd0);
    chk("t4_nop", id_instr, 32'h0000_0013);
    tick();
    chk("t4_addr", imem_req_addr, 32'h8000_0200);

    // Redirect in REQ while memory stalls: request stays, its response is dropped
    imem_req_ready = 1'b0;
    redirect(32'h8000_0300);
    tick();
    redirect_valid = 1'b0;
    chk("t4b_addr_stable", imem_req_addr, 32'h8000_0200);
    chk("t4b_req_valid", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    do_fetch(32'h0000_0033, 1'b0);
    chk("t4b_killed_valid", 32'(id_valid), 32'd0);
    chk("t4b_addr_new", imem_req_addr, 32'h8000_0300);

    // Access fault, recovery, then misaligned redirect
    do_fetch(32'h0000_0000, 1'b1);
    chk("t5_err", 32'(fetch_err), 32'd1);
    chk("t5_err_id_valid", 32'(id_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_err_no_req", 32'(imem_req_valid), 32'd0);
      chk("t5_err_sticky", 32'(fetch_err), 32'd1);
    end
    redirect(32'h8000_0000);
    tick();
    redirect_valid = 1'b0;
    chk("t5_err_clear", 32'(fetch_err), 32'd0);
    tick();
    chk("t5_resume_addr", imem_req_addr, 32'h8000_0000);
    do_fetch(32'h0000_0013, 1'b0);
    chk("t5_resume_pc", id_pc, 32'h8000_0000);
    redirect(32'h8000_0002);
    tick();
    redirect_valid = 1'b0;
    chk("t5_mis_idle_req", 32'(imem_req_valid), 32'd0);
    tick();
    chk("t5_mis_err", 32'(fetch_err), 32'd1);
    chk("t5_mis_no_req", 32'(imem_req_valid), 32'd0);

    // pc+4 wraps past the top of the address space
    redirect(32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0013, 1'b0);
    consume();
    chk("wrap_addr_zero", imem_req_addr, 32'h0000_0000);
    chk("wrap_no_err", 32'(fetch_err), 32'd0);

    // Reset asserted in WAIT, stale response around the release
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_id_pc", id_pc, 32'd0);
    chk("t6_rst_instr", id_instr, 32'h0000_0013);
    chk("t6_rst_addr", imem_req_addr, 32'h8000_0000);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    chk("t6_id_valid", 32'(id_valid), 32'd0);
    chk("t6_restart_addr", imem_req_addr, 32'h8000_0000);
    chk("t6_restart_req", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    tick();
    tick();
    chk("t6_wait_no_valid", 32'(id_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0030_0193;
    tick();
    imem_rsp_valid = 1'b0;
    chk("t6_id_pc", id_pc, 32'h8000_0000);
    chk("t6_instr", id_instr, 32'h0030_0193);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
